// File: rtl/dec5b6b_pkg.sv
// Shared state encodings, comma codewords and weight helper for the 5b/6b receive controller.
package dec5b6b_pkg;

  typedef logic [1:0] state_t;

  localparam state_t HUNT   = 2'd0;
  localparam state_t ALIGN  = 2'd1;
  localparam state_t LOCKED = 2'd2;

  localparam logic [5:0] COMMA_NEG = 6'b111100;
  localparam logic [5:0] COMMA_POS = 6'b000011;

  function automatic logic [2:0] ones6(input logic [5:0] w);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, w[i]};
    return n;
  endfunction

endpackage

// File: rtl/dec5b6b_lut.sv
// 5b/6b data decode table (bit order abcdei, a = MSB): payload plus legality of the word at rd_i (1 = RD+).
module dec5b6b_lut (
  input  logic [5:0] word_i,
  input  logic       rd_i,
  output logic [4:0] data_o,
  output logic       legal_o
);

  logic [6:0] ent;  // {legal at RD-, legal at RD+, payload}

  always_comb begin
    ent = 7'b0;
    case (word_i)
      6'b100111: ent = {2'b10, 5'd0};
      6'b011000: ent = {2'b01, 5'd0};
      6'b011101: ent = {2'b10, 5'd1};
      6'b100010: ent = {2'b01, 5'd1};
      6'b101101: ent = {2'b10, 5'd2};
      6'b010010: ent = {2'b01, 5'd2};
      6'b110001: ent = {2'b11, 5'd3};
      6'b110101: ent = {2'b10, 5'd4};
      6'b001010: ent = {2'b01, 5'd4};
      6'b101001: ent = {2'b11, 5'd5};
      6'b011001: ent = {2'b11, 5'd6};
      6'b111000: ent = {2'b10, 5'd7};
      6'b000111: ent = {2'b01, 5'd7};
      6'b111001: ent = {2'b10, 5'd8};
      6'b000110: ent = {2'b01, 5'd8};
      6'b100101: ent = {2'b11, 5'd9};
      6'b010101: ent = {2'b11, 5'd10};
      6'b110100: ent = {2'b11, 5'd11};
      6'b001101: ent = {2'b11, 5'd12};
      6'b101100: ent = {2'b11, 5'd13};
      6'b011100: ent = {2'b11, 5'd14};
      6'b010111: ent = {2'b10, 5'd15};
      6'b101000: ent = {2'b01, 5'd15};
      6'b011011: ent = {2'b10, 5'd16};
      6'b100100: ent = {2'b01, 5'd16};
      6'b100011: ent = {2'b11, 5'd17};
      6'b010011: ent = {2'b11, 5'd18};
      6'b110010: ent = {2'b11, 5'd19};
      6'b001011: ent = {2'b11, 5'd20};
      6'b101010: ent = {2'b11, 5'd21};
      6'b011010: ent = {2'b11, 5'd22};
      6'b111010: ent = {2'b10, 5'd23};
      6'b000101: ent = {2'b01, 5'd23};
      6'b110011: ent = {2'b10, 5'd24};
      6'b001100: ent = {2'b01, 5'd24};
      6'b100110: ent = {2'b11, 5'd25};
      6'b010110: ent = {2'b11, 5'd26};
      6'b110110: ent = {2'b10, 5'd27};
      6'b001001: ent = {2'b01, 5'd27};
      6'b001110: ent = {2'b11, 5'd28};
      6'b101110: ent = {2'b10, 5'd29};
      6'b010001: ent = {2'b01, 5'd29};
      6'b011110: ent = {2'b10, 5'd30};
      6'b100001: ent = {2'b01, 5'd30};
      6'b101011: ent = {2'b10, 5'd31};
      6'b010100: ent = {2'b01, 5'd31};
      default:   ent = 7'b0;
    endcase
    data_o  = ent[4:0];
    legal_o = rd_i ? ent[5] : ent[6];
  end

endmodule

// File: rtl/dec5b6b_sync_ctrl.sv
// Receive-side 5b/6b word-sync controller: deserialiser, comma hunt, RD tracking, windowed loss of sync.
// Define DEC5B6B_ERR_CNT_EN to build the saturating err_cnt counter; otherwise err_cnt is tied low.
module dec5b6b_sync_ctrl #(
  parameter int COMMA_LOCK = 3,
  parameter int ERR_WIN    = 64,
  parameter int ERR_MAX    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_vld,
  output logic [4:0]  data_out,
  output logic        data_vld,
  output logic        k_det,
  output logic        sync_ok,
  output logic        rd_out,
  output logic        code_err,
  output logic        disp_err,
  output logic [15:0] err_cnt
);
  import dec5b6b_pkg::*;

  // state  | meaning
  // HUNT   | bit-sliding search for a comma, no payload
  // ALIGN  | word-aligned, counting commas toward lock
  // LOCKED | payload delivered, errors counted per window

  localparam int CW = $clog2(COMMA_LOCK + 1);
  localparam int WW = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam int EW = $clog2(ERR_MAX + 1);

  state_t        state_q, state_d;
  logic [4:0]    sr_q, sr_d;  // previous five bits; the word under test is {sr_q, bit_in}
  logic [2:0]    phase_q, phase_d;
  logic          fill_q, fill_d;
  logic          rd_q, rd_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d;
  logic [WW-1:0] win_word_q, win_word_d;
  logic [EW-1:0] win_err_q, win_err_d;
  logic [4:0]    data_q, data_d;
  logic          dv_q, dv_d, k_q, k_d, ce_q, ce_d, de_q, de_d;

  logic [5:0]    word;
  logic [2:0]    w_ones;
  logic [4:0]    cur_data, alt_data, dec_data;
  logic          cur_legal, alt_legal, is_comma, comma_rd_ok;
  logic          c_err, d_err, rd_next, word_done, wrap;
  logic [CW-1:0] comma_inc;
  logic [EW-1:0] err_inc;

  assign word        = {sr_q, bit_in};
  assign w_ones      = ones6(word);
  assign is_comma    = (word == COMMA_NEG) || (word == COMMA_POS);
  assign comma_rd_ok = (word == COMMA_NEG) ? ~rd_q : rd_q;

  dec5b6b_lut u_lut_cur (.word_i(word), .rd_i(rd_q),  .data_o(cur_data), .legal_o(cur_legal));
  dec5b6b_lut u_lut_alt (.word_i(word), .rd_i(~rd_q), .data_o(alt_data), .legal_o(alt_legal));

  // A word found only in the other RD's table is a disparity error, not a code error.
  assign dec_data  = cur_legal ? cur_data : alt_data;
  assign c_err     = (w_ones < 3'd2) || (w_ones > 3'd4) || (!is_comma && !cur_legal && !alt_legal);
  assign d_err     = !c_err && (is_comma ? !comma_rd_ok : !cur_legal);
  assign rd_next   = (w_ones == 3'd4) ? 1'b1 : (w_ones == 3'd2) ? 1'b0 : rd_q;
  assign word_done = bit_vld && (phase_q == 3'd5);
  assign wrap      = (win_word_q == WW'(ERR_WIN - 1));
  assign comma_inc = comma_cnt_q + CW'(1);
  assign err_inc   = win_err_q + EW'(1);

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    phase_d     = phase_q;
    fill_d      = fill_q;
    rd_d        = rd_q;
    comma_cnt_d = comma_cnt_q;
    win_word_d  = win_word_q;
    win_err_d   = win_err_q;
    data_d      = data_q;
    dv_d        = 1'b0;
    k_d         = 1'b0;
    ce_d        = 1'b0;
    de_d        = 1'b0;
    if (bit_vld) begin
      sr_d    = word[4:0];
      phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
      if (phase_q == 3'd5) fill_d = 1'b1;
    end
    case (state_q)
      HUNT: begin
        // The reset-time zeros in sr are not line bits, so sliding starts with the sixth bit.
        if (bit_vld && (fill_q || phase_q == 3'd5) && is_comma) begin
          phase_d     = 3'd0;
          fill_d      = 1'b1;
          rd_d        = (word == COMMA_NEG);
          k_d         = 1'b1;
          comma_cnt_d = CW'(1);
          win_word_d  = '0;
          win_err_d   = '0;
          state_d     = (COMMA_LOCK == 1) ? LOCKED : ALIGN;
        end
      end
      ALIGN: begin
        if (word_done) begin
          rd_d = rd_next;
          if (c_err || d_err) begin
            ce_d        = c_err;
            de_d        = d_err;
            comma_cnt_d = '0;
            state_d     = HUNT;
          end else if (is_comma) begin
            k_d         = 1'b1;
            comma_cnt_d = comma_inc;
            if (comma_inc == CW'(COMMA_LOCK)) begin
              state_d    = LOCKED;
              win_word_d = '0;
              win_err_d  = '0;
            end
          end
        end
      end
      LOCKED: begin
        if (word_done) begin
          rd_d       = rd_next;
          win_word_d = wrap ? '0 : win_word_q + WW'(1);
          if (c_err || d_err) begin
            ce_d = c_err;
            de_d = d_err;
            if (err_inc == EW'(ERR_MAX)) begin
              state_d     = HUNT;
              comma_cnt_d = '0;
              win_err_d   = '0;
            end else begin
              win_err_d = wrap ? '0 : err_inc;
            end
          end else begin
            if (wrap) win_err_d = '0;
            if (is_comma) begin
              k_d = 1'b1;
            end else begin
              dv_d   = 1'b1;
              data_d = dec_data;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      phase_q     <= '0;
      fill_q      <= 1'b0;
      rd_q        <= 1'b0;
      comma_cnt_q <= '0;
      win_word_q  <= '0;
      win_err_q   <= '0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      k_q         <= 1'b0;
      ce_q        <= 1'b0;
      de_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      phase_q     <= phase_d;
      fill_q      <= fill_d;
      rd_q        <= rd_d;
      comma_cnt_q <= comma_cnt_d;
      win_word_q  <= win_word_d;
      win_err_q   <= win_err_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      k_q         <= k_d;
      ce_q        <= ce_d;
      de_q        <= de_d;
    end
  end

`ifdef DEC5B6B_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if ((ce_d || de_d) && (state_q != HUNT) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0;
`endif

  assign data_out = data_q;
  assign data_vld = dv_q;
  assign k_det    = k_q;
  assign code_err = ce_q;
  assign disp_err = de_q;
  assign sync_ok  = (state_q == LOCKED);
  assign rd_out   = rd_q;

endmodule

// File: tb/tb_dec5b6b_sync_ctrl.sv
// Directed scoreboard bench for dec5b6b_sync_ctrl at default parameters; err_cnt expectations follow DEC5B6B_ERR_CNT_EN.
module tb_dec5b6b_sync_ctrl;

  typedef struct packed {
    logic        dv;
    logic [4:0]  d;
    logic        k;
    logic        ce;
    logic        de;
    logic        so;
    logic        rd;
    logic [15:0] ec;
  } exp_t;

`ifdef DEC5B6B_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic        bit_vld;
  logic [4:0]  data_out;
  logic        data_vld, k_det, sync_ok, rd_out, code_err, disp_err;
  logic [15:0] err_cnt;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  last_data;
  int          err_total;

  dec5b6b_sync_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bit_in  (bit_in),
    .bit_vld (bit_vld),
    .data_out(data_out),
    .data_vld(data_vld),
    .k_det   (k_det),
    .sync_ok (sync_ok),
    .rd_out  (rd_out),
    .code_err(code_err),
    .disp_err(disp_err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    bit_in  = b;
    bit_vld = 1'b1;
    @(posedge clk);
    #1;
    bit_vld = 1'b0;
    bit_in  = 1'b0;
  endtask

  task automatic push_exp(input logic dv, input logic [4:0] d, input logic k, ce, de, so, rd);
    exp_t e;
    if (dv) last_data = d;
    if (ce || de) err_total++;
    e.dv = dv;
    e.d  = last_data;
    e.k  = k;
    e.ce = ce;
    e.de = de;
    e.so = so;
    e.rd = rd;
    e.ec = CNT_ON ? 16'(err_total) : 16'h0;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, " data_vld"}, 16'(data_vld), 16'(e.dv));
      chk({tag, " data_out"}, 16'(data_out), 16'(e.d));
      chk({tag, " k_det"},    16'(k_det),    16'(e.k));
      chk({tag, " code_err"}, 16'(code_err), 16'(e.ce));
      chk({tag, " disp_err"}, 16'(disp_err), 16'(e.de));
      chk({tag, " sync_ok"},  16'(sync_ok),  16'(e.so));
      chk({tag, " rd_out"},   16'(rd_out),   16'(e.rd));
      chk({tag, " err_cnt"},  err_cnt,       e.ec);
    end
  endtask

  // Expected outputs one clk after the word's last bit: dv, d, k, ce, de, sync_ok, rd.
  task automatic send_word(input string tag, input logic [5:0] w, input int gap,
                           input logic dv, input logic [4:0] d, input logic k, ce, de, so, rd);
    push_exp(dv, d, k, ce, de, so, rd);
    for (int i = 5; i >= 0; i--) begin
      drive_bit(w[i]);
      if (i == 3) repeat (gap) @(posedge clk);
    end
    check_out(tag);
  endtask

  initial begin
    rst       = 1'b1;
    bit_in    = 1'b0;
    bit_vld   = 1'b0;
    last_data = 5'd0;
    err_total = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst data_out", 16'(data_out), 16'h0);
    chk("rst data_vld", 16'(data_vld), 16'h0);
    chk("rst k_det",    16'(k_det),    16'h0);
    chk("rst sync_ok",  16'(sync_ok),  16'h0);
    chk("rst rd_out",   16'(rd_out),   16'h0);
    chk("rst code_err", 16'(code_err), 16'h0);
    chk("rst disp_err", 16'(disp_err), 16'h0);
    chk("rst err_cnt",  err_cnt,       16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Two junk bits then 111100: alignment only on the eighth bit.
    drive_bit(1'b1); drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
    chk("hunt bit7 k_det", 16'(k_det), 16'h0);
    chk("hunt bit7 sync_ok", 16'(sync_ok), 16'h0);
    push_exp(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0);
    check_out("hunt comma");

    send_word("align d0",    6'b011000, 0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word("align comma2",6'b111100, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word("align d0 b",  6'b011000, 0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word("lock comma3", 6'b111100, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word("locked d0",   6'b011000, 0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word("wt2 at rd-",  6'b011000, 0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_word("d3 gap",      6'b110001, 2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word("d0 rd-",      6'b100111, 0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word("111000 rd+",  6'b111000, 0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word("d7 rd+",      6'b000111, 0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word("comma rd+",   6'b000011, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word("d31 rd-",     6'b101011, 0, 1'b1, 5'd31,1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word("win1 err3",   6'b111111, 0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 10; i <= 64; i++)
      send_word("win1 fill", 6'b110001, 0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word("win2 err1",   6'b111111, 0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    send_word("win2 err2",   6'b111111, 0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    send_word("win2 err3",   6'b111111, 0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 3; i <= 62; i++)
      send_word("win2 fill", 6'b110001, 0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word("wrap word err4", 6'b111111, 0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    send_word("relock c1",   6'b111100, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word("relock c2",   6'b000011, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word("relock c3",   6'b111100, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++)
      send_word("err_max run", 6'b111111, 0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, (i < 4), 1'b1);

    send_word("hunt c1",     6'b111100, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word("align err",   6'b111111, 0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send_word("rehunt c1",   6'b111100, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word("rehunt c2",   6'b000011, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word("rehunt c3",   6'b111100, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    send_word("relock d3",   6'b110001, 2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a word: partial bits are discarded.
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst sync_ok",  16'(sync_ok),  16'h0);
    chk("midrst err_cnt",  err_cnt,       16'h0);
    chk("midrst rd_out",   16'(rd_out),   16'h0);
    chk("midrst data_out", 16'(data_out), 16'h0);
    last_data = 5'd0;
    err_total = 0;
    @(negedge clk);
    rst = 1'b0;
    send_word("postrst comma", 6'b111100, 0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word("postrst d0",    6'b011000, 0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
